// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - mdu_op_e    : operation codes driven by the Execute stage
//   - mdu_state_e : sequencing states of the HI/LO controller
//   - is_long_op  : true for the multi-cycle MUL/DIV class
package mdu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } mdu_state_e;

    // MULT, MULTU, DIV and DIVU occupy the low codes; everything above
    // is either a single-cycle move or an unused code.
    function automatic logic is_long_op(logic [2:0] op);
        return (op <= MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_hilo_ctrl_if.sv
// mdu_hilo_ctrl_if: Execute-stage <-> MDU controller bundle.
//   master (Execute side): drives start_i, op_i, a_i, b_i, flush_i
//   slave  (MDU side)    : drives stall_o, busy_o, done_o, hi_o, lo_o
interface mdu_hilo_ctrl_if;
    import mdu_pkg::*;

    logic            start_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            flush_i;
    logic            stall_o;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] hi_o;
    logic [XLEN-1:0] lo_o;

    modport master (
        output start_i, op_i, a_i, b_i, flush_i,
        input  stall_o, busy_o, done_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, flush_i,
        output stall_o, busy_o, done_o, hi_o, lo_o
    );

endinterface

// File: rtl/div_radix2_step.sv
// div_radix2_step: one combinational restoring-division step.
//   rem_i     : partial remainder (always < divisor_i)
//   quo_i     : shift register holding the remaining dividend bits in its
//               top, and the quotient bits produced so far in its bottom
//   divisor_i : divisor magnitude (non-zero)
//   rem_o     : updated partial remainder
//   quo_o     : quo_i shifted left with the new quotient bit in bit 0
module div_radix2_step
    import mdu_pkg::*;
(
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // The shifted remainder needs one extra bit; since rem_i < divisor_i,
    // a successful subtraction never sets the top bit of diff, so that bit
    // acts as the borrow.
    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        diff    = shifted - {1'b0, divisor_i};
        if (!diff[XLEN]) begin
            rem_o = diff[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b1};
        end else begin
            rem_o = shifted[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mdu_hilo_ctrl.sv
// mdu_hilo_ctrl: sequences MULT/MULTU/DIV/DIVU, executes MTHI/MTLO and owns
// the architectural HI/LO registers.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of mdu_hilo_ctrl_if (start/op/operands/flush in;
//              stall/busy/done and HI/LO out)
// Parameters: MUL_LAT cycles spent in MUL (>= 1), DIV_ITER division steps.
module mdu_hilo_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_LAT  = 2,
    parameter int DIV_ITER = 32
) (
    input  logic             clk,
    input  logic             rst,
    mdu_hilo_ctrl_if.slave   bus
);

    localparam int CNT_MAX = (MUL_LAT > DIV_ITER) ? MUL_LAT : DIV_ITER;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    mdu_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] opA_q, opA_d;     // multiplicand, or dividend/quotient shifter
    logic [XLEN-1:0] opB_q, opB_d;     // multiplier, or divisor magnitude
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic            mulSigned_q, mulSigned_d;
    logic            negQ_q, negQ_d;
    logic            negR_q, negR_d;
    logic            stall;

    logic [XLEN-1:0] stepRem, stepQuo;
    logic [2*XLEN-1:0] extA, extB, product;

    div_radix2_step u_step (
        .rem_i     (rem_q),
        .quo_i     (opA_q),
        .divisor_i (opB_q),
        .rem_o     (stepRem),
        .quo_o     (stepQuo)
    );

    // Sign- or zero-extending to 64 bits lets a single unsigned 64-bit
    // multiply produce both the MULT and MULTU results.
    always_comb begin
        extA    = {{XLEN{mulSigned_q & opA_q[XLEN-1]}}, opA_q};
        extB    = {{XLEN{mulSigned_q & opB_q[XLEN-1]}}, opB_q};
        product = extA * extB;
    end

    // State and datapath registers; reset wins over everything, including flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            opA_q       <= '0;
            opB_q       <= '0;
            rem_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            mulSigned_q <= 1'b0;
            negQ_q      <= 1'b0;
            negR_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            opA_q       <= opA_d;
            opB_q       <= opB_d;
            rem_q       <= rem_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            mulSigned_q <= mulSigned_d;
            negQ_q      <= negQ_d;
            negR_q      <= negR_d;
        end
    end

    // Next-state and datapath control. A flush in any busy state returns to
    // IDLE without touching HI/LO; a flush in IDLE swallows a same-cycle start.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        opA_d       = opA_q;
        opB_d       = opB_q;
        rem_d       = rem_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        mulSigned_d = mulSigned_q;
        negQ_d      = negQ_q;
        negR_d      = negR_q;
        stall       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                stall = bus.start_i && is_long_op(bus.op_i);
                if (bus.start_i && !bus.flush_i) begin
                    case (bus.op_i)
                        MDU_MTHI: hi_d = bus.a_i;
                        MDU_MTLO: lo_d = bus.a_i;
                        MDU_MULT, MDU_MULTU: begin
                            opA_d       = bus.a_i;
                            opB_d       = bus.b_i;
                            mulSigned_d = (bus.op_i == MDU_MULT);
                            cnt_d       = '0;
                            state_d     = ST_MUL;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            if (bus.b_i == '0) begin
                                state_d = ST_DONE;
                            end else begin
                                negQ_d  = (bus.op_i == MDU_DIV) && (bus.a_i[XLEN-1] ^ bus.b_i[XLEN-1]);
                                negR_d  = (bus.op_i == MDU_DIV) && bus.a_i[XLEN-1];
                                opA_d   = ((bus.op_i == MDU_DIV) && bus.a_i[XLEN-1]) ? -bus.a_i : bus.a_i;
                                opB_d   = ((bus.op_i == MDU_DIV) && bus.b_i[XLEN-1]) ? -bus.b_i : bus.b_i;
                                rem_d   = '0;
                                cnt_d   = '0;
                                state_d = ST_DIV;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            ST_MUL: begin
                stall = 1'b1;
                if (bus.flush_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(MUL_LAT - 1)) begin
                    hi_d    = product[2*XLEN-1:XLEN];
                    lo_d    = product[XLEN-1:0];
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DIV: begin
                stall = 1'b1;
                if (bus.flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    opA_d = stepQuo;
                    rem_d = stepRem;
                    if (cnt_q == CNT_W'(DIV_ITER - 1)) begin
                        state_d = ST_FIX;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_FIX: begin
                stall = 1'b1;
                if (bus.flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    lo_d    = negQ_q ? -opA_q : opA_q;
                    hi_d    = negR_q ? -rem_q : rem_q;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.stall_o = stall;
    assign bus.busy_o  = (state_q != ST_IDLE);
    assign bus.done_o  = (state_q == ST_DONE);
    assign bus.hi_o    = hi_q;
    assign bus.lo_o    = lo_q;

endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// tb_mdu_hilo_ctrl: scoreboard bench for mdu_hilo_ctrl.
// Stimulus pushes the expected HI/LO, latency and stall count of each
// MUL/DIV-class instruction; a monitor pops one entry per done_o pulse.
module tb_mdu_hilo_ctrl;
    import mdu_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        int          stalls;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cycleCnt = 0;
    int   startCycle = 0;
    int   stallCnt = 0;
    logic [31:0] refHi = '0;
    logic [31:0] refLo = '0;
    exp_t sbQ[$];

    mdu_hilo_ctrl_if bus ();

    mdu_hilo_ctrl #(.MUL_LAT(2), .DIV_ITER(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Cycle index, read by the monitor to measure start-to-done latency.
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural rules.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic        isLong;
        longint      sq, sr;
        logic [63:0] uq, ur;
        isLong = (op <= 3'd3);
        e.hi = refHi;
        e.lo = refLo;
        e.lat = 0;
        e.stalls = 0;
        case (op)
            3'd0: begin
                sq = longint'($signed(a)) * longint'($signed(b));
                e.hi = sq[63:32]; e.lo = sq[31:0]; e.lat = 3; e.stalls = 3;
            end
            3'd1: begin
                uq = {32'd0, a} * {32'd0, b};
                e.hi = uq[63:32]; e.lo = uq[31:0]; e.lat = 3; e.stalls = 3;
            end
            3'd2: begin
                if (b == 0) begin
                    e.lat = 1; e.stalls = 1;
                end else begin
                    sq = longint'($signed(a)) / longint'($signed(b));
                    sr = longint'($signed(a)) % longint'($signed(b));
                    e.lo = sq[31:0]; e.hi = sr[31:0]; e.lat = 34; e.stalls = 34;
                end
            end
            3'd3: begin
                if (b == 0) begin
                    e.lat = 1; e.stalls = 1;
                end else begin
                    uq = {32'd0, a} / {32'd0, b};
                    ur = {32'd0, a} % {32'd0, b};
                    e.lo = uq[31:0]; e.hi = ur[31:0]; e.lat = 34; e.stalls = 34;
                end
            end
            3'd4: refHi = a;
            3'd5: refLo = a;
            default: ;
        endcase
        if (isLong) begin
            refHi = e.hi;
            refLo = e.lo;
            sbQ.push_back(e);
        end
        @(posedge clk); #1;
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        @(negedge clk);
        checkOutput("stall_at_issue", {63'd0, bus.stall_o}, {63'd0, isLong});
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        if (!isLong) begin
            checkOutput("hi_after_move", {32'd0, bus.hi_o}, {32'd0, refHi});
            checkOutput("lo_after_move", {32'd0, bus.lo_o}, {32'd0, refLo});
            checkOutput("busy_after_move", {63'd0, bus.busy_o}, 64'd0);
        end
    endtask

    task automatic waitIdle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((bus.busy_o || sbQ.size() != 0) && n < 80);
        if (n >= 80) begin
            checks++;
            failures++;
            $display("[TB] FAIL wait_idle_timeout busy=%0d pending=%0d required=idle", bus.busy_o, sbQ.size());
        end
    endtask

    // Starts an op and flushes it in cycle T+flushAt; HI/LO must stay put.
    task automatic flushedOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int flushAt);
        @(posedge clk); #1;
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (flushAt - 1) @(posedge clk);
        #1 bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        checkOutput("busy_after_flush", {63'd0, bus.busy_o}, 64'd0);
        checkOutput("hi_after_flush", {32'd0, bus.hi_o}, {32'd0, refHi});
        checkOutput("lo_after_flush", {32'd0, bus.lo_o}, {32'd0, refLo});
        repeat (3) @(negedge clk);
    endtask

    // Monitor: counts stall cycles from each accepted start and scores every done_o.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.start_i && !bus.busy_o && !bus.flush_i) begin
                    startCycle = cycleCnt;
                    stallCnt   = 0;
                end
                if (bus.start_i && bus.busy_o && !bus.done_o) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL start_while_busy actual=1 required=0");
                end
                if (bus.stall_o) stallCnt++;
                if (bus.done_o) begin
                    if (sbQ.size() == 0) begin
                        checkOutput("unexpected_done", 64'd1, 64'd0);
                    end else begin
                        e = sbQ.pop_front();
                        checkOutput("done_hi", {32'd0, bus.hi_o}, {32'd0, e.hi});
                        checkOutput("done_lo", {32'd0, bus.lo_o}, {32'd0, e.lo});
                        checkOutput("done_latency", 64'(cycleCnt - startCycle), 64'(e.lat));
                        checkOutput("stall_cycles", 64'(stallCnt), 64'(e.stalls));
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog_expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        bus.start_i = 1'b0;
        bus.op_i    = 3'd0;
        bus.a_i     = '0;
        bus.b_i     = '0;
        bus.flush_i = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_hi", {32'd0, bus.hi_o}, 64'd0);
        checkOutput("reset_lo", {32'd0, bus.lo_o}, 64'd0);
        checkOutput("reset_busy", {63'd0, bus.busy_o}, 64'd0);
        checkOutput("reset_done", {63'd0, bus.done_o}, 64'd0);
        checkOutput("reset_stall", {63'd0, bus.stall_o}, 64'd0);

        // Directed cases.
        applyStimulus(3'd1, 32'hFFFF_FFFF, 32'd2);       waitIdle();
        applyStimulus(3'd0, 32'hFFFF_FFFD, 32'd5);       waitIdle();
        applyStimulus(3'd3, 32'd100, 32'd7);             waitIdle();
        applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd2);       waitIdle();
        applyStimulus(3'd5, 32'h55, 32'd0);              waitIdle();
        applyStimulus(3'd4, 32'hAA, 32'd0);              waitIdle();
        applyStimulus(3'd2, 32'd2, 32'd0);               waitIdle();
        applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF); waitIdle();

        // DIVU flushed in its 10th DIV cycle, then an MTHI with no stall.
        flushedOp(3'd3, 32'd1000, 32'd3, 10);
        applyStimulus(3'd4, 32'h1234, 32'd0);            waitIdle();
        // Flush in the last MUL cycle and in FIX.
        flushedOp(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 2);
        flushedOp(3'd2, 32'hFFFF_0000, 32'd3, 33);

        // Flush in IDLE swallows a same-cycle MTLO.
        @(posedge clk); #1;
        bus.start_i = 1'b1; bus.op_i = 3'd5; bus.a_i = 32'hBEEF; bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0; bus.flush_i = 1'b0;
        checkOutput("lo_flush_idle", {32'd0, bus.lo_o}, {32'd0, refLo});

        // A start presented during DONE is ignored.
        applyStimulus(3'd1, 32'd6, 32'd7);
        repeat (2) @(posedge clk);
        #1 bus.start_i = 1'b1; bus.op_i = 3'd4; bus.a_i = 32'hDEAD;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        waitIdle();
        checkOutput("hi_start_in_done", {32'd0, bus.hi_o}, {32'd0, refHi});

        // Reset in the middle of a division.
        @(posedge clk); #1;
        bus.start_i = 1'b1; bus.op_i = 3'd3; bus.a_i = 32'd77; bus.b_i = 32'd5;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        refHi = '0;
        refLo = '0;
        checkOutput("midop_reset_hi", {32'd0, bus.hi_o}, 64'd0);
        checkOutput("midop_reset_lo", {32'd0, bus.lo_o}, 64'd0);
        checkOutput("midop_reset_busy", {63'd0, bus.busy_o}, 64'd0);
        repeat (2) @(negedge clk);

        // Randomized mix, including unused op codes and edge operands.
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       a = 32'h8000_0000;
                1:       a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'd1;
                2:       b = 32'hFFFF_FFFF;
                3:       b = 32'($urandom_range(2, 40));
                default: b = $urandom;
            endcase
            applyStimulus(op, a, b);
            waitIdle();
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", 64'(sbQ.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu_hilo_ctrl.md
Name: mdu_hilo_ctrl

Overview:
- Controls the multiply/divide unit (MDU) and owns the architectural HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the Execute stage and sequences the multi-cycle arithmetic.
- Raises a pipeline stall request while an operation is in progress, then commits the result to HI/LO.
- Provides HI/LO values for MFHI/MFLO, and handles abort on flush.

Parameters:
- MUL_LAT, 2, number of cycles spent in the MUL state (minimum 1).
- DIV_ITER, 32, number of restoring-division iterations (fixed at the data width).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start_i  in  1  Execute stage holds a valid MDU instruction.
- op_i  in  3  operation code, from the shared package.
- a_i  in  32  rs operand (dividend or multiplicand).
- b_i  in  32  rt operand (divisor or multiplier).
- flush_i  in  1  abort the current operation (exception or redirect).
- stall_o  out  1  stall request to the hazard unit.
- busy_o  out  1  FSM is not IDLE.
- done_o  out  1  one-cycle pulse; HI/LO were updated by a MUL or DIV.
- hi_o  out  32  current HI register.
- lo_o  out  32  current LO register.

Behaviour:
- Reset: state=IDLE, hi_o=0, lo_o=0, busy_o=0, done_o=0, stall_o=0, iteration counter=0.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- Cycle T (IDLE, start_i=1):
  - MTHI: hi<=a_i at the edge ending T. No stall, FSM stays IDLE.
  - MTLO: lo<=a_i at the edge ending T. No stall, FSM stays IDLE.
  - MULT/MULTU: latch operands, go to MUL.
  - DIV/DIVU with b_i!=0: latch absolute values and sign flags, clear the remainder, go to DIV.
  - DIV/DIVU with b_i==0: go directly to DONE. HI/LO are unchanged, done_o=1 in T+1.
- stall_o is combinational:
  - high when (state==IDLE and start_i and op is MUL/DIV class), or state is MUL, DIV or FIX;
  - low in IDLE otherwise, and low in DONE.
- MUL:
  - Product is 64 bits: signed for MULT, unsigned for MULTU.
  - Stays MUL_LAT cycles.
  - {hi,lo}<=product on the edge leaving the last MUL cycle, then goes to DONE.
  - With the default MUL_LAT=2: stall in T..T+2, DONE in T+3.
- DIV:
  - One restoring step per cycle for DIV_ITER cycles.
  - Then FIX for one cycle, which applies signs:
    - quotient is negated if sign(a) XOR sign(b);
    - remainder takes the sign of a.
  - FIX writes lo<=quotient and hi<=remainder, then goes to DONE.
  - Timing: stall in T..T+33, DONE in T+34.
- DONE: done_o=1 and stall_o=0; the instruction leaves Execute. start_i is ignored in DONE. Next state is IDLE.
- flush_i=1 in any state except IDLE:
  - next state is IDLE;
  - no HI/LO write, even in the final MUL cycle or in FIX;
  - done_o stays 0.
- flush_i=1 in IDLE: a start_i in the same cycle is ignored, including MTHI/MTLO.
- rst has priority over flush_i; rst mid-operation gives the reset values above.
- start_i while state is not IDLE/DONE is ignored. The bench asserts it never occurs, since the pipeline is stalled.
- hi_o/lo_o are registered. There is no internal forwarding; the hazard unit stalls MFHI/MFLO when busy_o=1.
- Invalid op_i codes are treated as no-op.

Decomposition:
- Shared package, mdu_pkg:
  - op codes: MDU_MULT=0, MDU_MULTU=1, MDU_DIV=2, MDU_DIVU=3, MDU_MTHI=4, MDU_MTLO=5;
  - FSM state encoding;
  - helper function is_long_op(op).
- Sub-module div_radix2_step: combinational single restoring-division step (remainder, quotient shift-in).
- The FSM, counter and HI/LO registers stay in mdu_hilo_ctrl.

Test Plan:
- MULTU a=0xFFFFFFFF, b=2 -> stall 3 cycles, done_o in T+3, hi=0x00000001, lo=0xFFFFFFFE.
- MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIVU a=100, b=7 -> stall_o high exactly 34 cycles, lo=14, hi=2.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIV a=2 (after MTLO 0x55 and MTHI 0xAA), b=0 -> done_o in T+1, hi=0xAA, lo=0x55 unchanged.
- DIVU started, flush_i at the 10th DIV cycle -> IDLE next cycle, HI/LO unchanged, no done_o. A following MTHI 0x1234 writes hi=0x1234 with no stall.
